// File: rtl/proc_sequencer_if.sv
// proc_sequencer_if: start/memory/processor handshake bundle around proc_sequencer.
// step_mode/step exist only when PROC_SEQ_STEP_EN is defined.
interface proc_sequencer_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_rdata;
  logic [15:0]       iin;
  logic              proc_run;
  logic              proc_done;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       instr_count;
  logic              busy;
  logic              halted;
  logic              timeout_err;
`ifdef PROC_SEQ_STEP_EN
  logic              step_mode;
  logic              step;
`endif
  modport master (
`ifdef PROC_SEQ_STEP_EN
    input  step_mode, step,
`endif
    input  start, start_addr, mem_rdata, proc_done,
    output mem_rd, mem_addr, iin, proc_run, pc, instr_count, busy, halted, timeout_err
  );
  modport slave (
`ifdef PROC_SEQ_STEP_EN
    output step_mode, step,
`endif
    output start, start_addr, mem_rdata, proc_done,
    input  mem_rd, mem_addr, iin, proc_run, pc, instr_count, busy, halted, timeout_err
  );
endinterface

// File: rtl/proc_sequencer.sv
// proc_sequencer: fetches program words and feeds them to the processor's iin port.
// Optional single-step PAUSE state enabled by defining PROC_SEQ_STEP_EN.
module proc_sequencer #(
  parameter int         ADDR_W  = 8,
  parameter logic [2:0] HALT_OP = 3'b111,
  parameter int         TIMEOUT = 32
) (
  input logic              clock,
  input logic              resetn,
  proc_sequencer_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, EXEC, HALT, ERR
`ifdef PROC_SEQ_STEP_EN
    , PAUSE
`endif
  } state_e;
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       iin_q, iin_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       wd_q, wd_d;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      pc_q    <= '0;
      iin_q   <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      iin_q   <= iin_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    iin_d   = iin_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    unique case (state_q)
      IDLE, HALT, ERR: if (bus.start) begin
        state_d = FETCH;
        pc_d    = bus.start_addr;
        cnt_d   = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: if (bus.mem_rdata[15:13] == HALT_OP) state_d = HALT;
      else begin
        iin_d   = bus.mem_rdata;
        wd_d    = '0;
        state_d = EXEC;
      end
      EXEC: if (bus.proc_done) begin
        pc_d  = pc_q + 1'b1;
        cnt_d = cnt_q + 1'b1;
`ifdef PROC_SEQ_STEP_EN
        state_d = bus.step_mode ? PAUSE : FETCH;
`else
        state_d = FETCH;
`endif
      end else begin
        // pc is left alone on timeout so it still names the stuck instruction
        wd_d    = wd_q + 1'b1;
        state_d = (wd_d == 16'(TIMEOUT)) ? ERR : EXEC;
      end
`ifdef PROC_SEQ_STEP_EN
      PAUSE: state_d = bus.step ? FETCH : PAUSE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.mem_rd      = state_q == FETCH;
    bus.proc_run    = state_q == EXEC;
    bus.busy        = !(state_q inside {IDLE, HALT, ERR});
    bus.halted      = state_q == HALT;
    bus.timeout_err = state_q == ERR;
    bus.mem_addr    = pc_q;
    bus.pc          = pc_q;
    bus.iin         = iin_q;
    bus.instr_count = cnt_q;
  end
endmodule

// File: tb/tb_proc_sequencer.sv
// tb_proc_sequencer: random programs against a slot-counting program model of the sequencer.
module tb_proc_sequencer;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic resetn;
  logic sm, st;
  logic [15:0] mem [256];
  proc_sequencer_if #(.ADDR_W(8)) bus();
  proc_sequencer #(.ADDR_W(8), .HALT_OP(3'b111), .TIMEOUT(TO)) dut (
    .clock(clk), .resetn(resetn), .bus(bus)
  );
`ifdef PROC_SEQ_STEP_EN
  assign bus.step_mode = sm;
  assign bus.step      = st;
`endif
  initial forever #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  bit chk_en = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // program memory: data appears the cycle after a read strobe
  logic rd_seen = 0;
  logic [7:0] addr_seen = 0;
  initial begin
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      bus.mem_rdata = rd_seen ? mem[addr_seen] : 16'hDEAD;
      rd_seen   = bus.mem_rd;
      addr_seen = bus.mem_addr;
    end
  end

  // processor: done on the (done_dly+1)-th run cycle; optional junk done while not running
  int done_dly = 3, run_cnt = 0;
  bit rand_dly = 0, spurious = 0;
  initial begin
    bus.proc_done = 1'b0;
    forever begin
      @(negedge clk);
      run_cnt = bus.proc_run ? run_cnt + 1 : 0;
      if (rand_dly && run_cnt == 1) done_dly = $urandom_range(0, 9);
      bus.proc_done = bus.proc_run ? (run_cnt == done_dly + 1) : (spurious && $urandom_range(0, 1) == 1);
    end
  end

  // reference: slot -1 paused, 0 fetch, 1 load, k+1 is the k-th exec cycle
  bit m_active = 0, m_halted = 0, m_err = 0;
  int m_slot = 0;
  logic [7:0] m_pc = 0;
  logic [15:0] m_iin = 0, m_cnt = 0;
  initial forever begin
    @(posedge clk);
    if (!resetn) begin
      m_active = 0; m_slot = 0; m_halted = 0; m_err = 0; m_pc = 0; m_iin = 0; m_cnt = 0;
    end else if (!m_active) begin
      if (bus.start) begin
        m_active = 1; m_slot = 0; m_pc = bus.start_addr; m_cnt = 0; m_halted = 0; m_err = 0;
      end
    end else if (m_slot < 0) begin
      if (st) m_slot = 0;
    end else if (m_slot < 2) begin
      if (m_slot == 1 && mem[m_pc][15:13] == 3'b111) begin
        m_active = 0; m_halted = 1;
      end else begin
        if (m_slot == 1) m_iin = mem[m_pc];
        m_slot++;
      end
    end else if (bus.proc_done) begin
      m_pc++; m_cnt++;
      m_slot = sm ? -1 : 0;
    end else if (m_slot - 1 == TO) begin
      m_active = 0; m_err = 1;
    end else m_slot++;
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("mem_rd", bus.mem_rd, m_active && m_slot == 0);
      chk("proc_run", bus.proc_run, m_active && m_slot >= 2);
      chk("busy", bus.busy, m_active);
      chk("halted", bus.halted, m_halted);
      chk("timeout_err", bus.timeout_err, m_err);
      chk("pc", bus.pc, m_pc);
      chk("mem_addr", bus.mem_addr, m_pc);
      chk("iin", bus.iin, m_iin);
      chk("instr_count", bus.instr_count, m_cnt);
    end
  end

  task automatic pulse_start(logic [7:0] a);
    bus.start_addr = a; bus.start = 1; @(negedge clk); bus.start = 0;
  endtask

  logic [15:0] iq[$];
  task automatic run_idle(int lim, output int runs);
    logic pr = 0;
    int k = 0;
    runs = 0;
    iq.delete();
    while (bus.busy && k < lim) begin
      if (bus.proc_run) runs++;
      if (bus.proc_run && !pr) iq.push_back(bus.iin);
      pr = bus.proc_run;
      @(negedge clk);
      k++;
    end
    chk("idle_bound", bus.busy, 0);
  endtask

  task automatic load_basic();
    mem[0] = 16'hA002; mem[1] = 16'hA407; mem[2] = 16'h2400; mem[3] = 16'h8400; mem[4] = 16'hE000;
  endtask

  int r;
  logic [3:0] exp_rd, exp_run;
  logic [15:0] w;
  logic [7:0] base;
  initial begin
    resetn = 0; bus.start = 0; bus.start_addr = 0; sm = 0; st = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    chk("rst_pc", bus.pc, 0);
    chk("rst_iin", bus.iin, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_run", bus.proc_run, 0);
    resetn = 1;
    @(negedge clk);

    load_basic();
    done_dly = 3;
    pulse_start(8'h00);
    chk("basic_fetch_t1", bus.mem_rd, 1);
    run_idle(200, r);
    chk("basic_len", iq.size(), 4);
    if (iq.size() == 4) begin
      chk("basic_i0", iq[0], 16'hA002);
      chk("basic_i1", iq[1], 16'hA407);
      chk("basic_i2", iq[2], 16'h2400);
      chk("basic_i3", iq[3], 16'h8400);
    end
    chk("basic_halted", bus.halted, 1);
    chk("basic_pc", bus.pc, 4);
    chk("basic_cnt", bus.instr_count, 4);
    chk("basic_run", bus.proc_run, 0);

    done_dly = 0;
    exp_rd = 4'b1001; exp_run = 4'b0100;
    pulse_start(8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("tim_rd", bus.mem_rd, exp_rd[i]);
      chk("tim_run", bus.proc_run, exp_run[i]);
      @(negedge clk);
    end
    run_idle(200, r);

    mem[8'h10] = 16'h1234; mem[8'h20] = 16'hE000;
    done_dly = 1000;
    pulse_start(8'h10);
    run_idle(100, r);
    chk("wd_cycles", r, TO);
    chk("wd_err", bus.timeout_err, 1);
    chk("wd_pc", bus.pc, 8'h10);
    chk("wd_cnt", bus.instr_count, 0);
    pulse_start(8'h20);
    chk("wd_clear", bus.timeout_err, 0);
    chk("wd_restart_busy", bus.busy, 1);
    run_idle(100, r);
    chk("wd_rehalt", bus.halted, 1);

    mem[8'hFF] = 16'h4000; mem[8'h00] = 16'hE000;
    done_dly = 3; spurious = 1;
    pulse_start(8'hFF);
    for (int i = 0; i < 5; i++) begin
      bus.start = i[0]; bus.start_addr = 8'($urandom);
      @(negedge clk);
    end
    bus.start = 0;
    run_idle(100, r);
    spurious = 0;
    chk("wrap_halted", bus.halted, 1);
    chk("wrap_pc", bus.pc, 0);
    chk("wrap_cnt", bus.instr_count, 1);

    load_basic();
    done_dly = 1000;
    pulse_start(8'h00);
    for (int i = 0; i < 10 && !bus.proc_run; i++) @(negedge clk);
    chk("rst_mid_exec", bus.proc_run, 1);
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    chk("rstm_run", bus.proc_run, 0);
    chk("rstm_rd", bus.mem_rd, 0);
    chk("rstm_busy", bus.busy, 0);
    chk("rstm_pc", bus.pc, 0);
    chk("rstm_iin", bus.iin, 0);
    chk("rstm_cnt", bus.instr_count, 0);
    chk("rstm_err", {bus.halted, bus.timeout_err}, 0);

    rand_dly = 1;
    for (int n = 0; n < 20; n++) begin
      base = 8'($urandom);
      w = 16'($urandom_range(1, 5));
      for (int i = 0; i < 6; i++) begin
        mem[8'(base + i)] = 16'($urandom);
        if (mem[8'(base + i)][15:13] == 3'b111) mem[8'(base + i)][15:13] = 3'b011;
      end
      mem[8'(base + w)] = {3'b111, 13'($urandom)};
      pulse_start(base);
      run_idle(400, r);
    end
    rand_dly = 0;

`ifdef PROC_SEQ_STEP_EN
    load_basic();
    sm = 1; done_dly = 0;
    pulse_start(8'h00);
    for (int s = 0; s < 4; s++) begin
      repeat (10) @(negedge clk);
      chk("step_busy", bus.busy, 1);
      chk("step_idle_rd", bus.mem_rd, 0);
      chk("step_pc", bus.pc, s + 1);
      st = 1; @(negedge clk); st = 0;
      chk("step_fetch", bus.mem_rd, 1);
    end
    run_idle(100, r);
    chk("step_halted", bus.halted, 1);
    chk("step_cnt", bus.instr_count, 4);
    sm = 0;
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
